// File: rtl/nvm_gc_engine.sv
// Greedy garbage-collection engine: scans block metadata for the block with the
// fewest valid pages, relocates its valid pages, then erases it.
module nvm_gc_engine #(
  parameter int BLOCK_W = 10,
  parameter int PAGE_W  = 6,
  parameter logic [BLOCK_W:0] GC_THRESHOLD = (BLOCK_W+1)'(8)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [BLOCK_W:0]   free_blk_cnt,
  input  logic               gc_force,
  input  logic               host_req,
  input  logic [BLOCK_W-1:0] active_blk,
  output logic [BLOCK_W-1:0] meta_blk,
  input  logic [PAGE_W:0]    meta_vcnt,
  input  logic               meta_free,
  output logic [BLOCK_W-1:0] pv_blk,
  output logic [PAGE_W-1:0]  pv_page,
  input  logic               pv_valid,
  output logic               cmd_valid,
  output logic [1:0]         cmd_op,
  output logic [BLOCK_W-1:0] cmd_blk,
  output logic [PAGE_W-1:0]  cmd_page,
  input  logic               cmd_ready,
  input  logic               cmd_done,
  output logic               gc_busy,
  output logic               gc_paused,
  output logic               gc_done,
  output logic               gc_nogain,
  output logic [BLOCK_W-1:0] gc_victim
);
  localparam int BLOCK_NUM = 1 << BLOCK_W;
  localparam int PAGE_NUM  = 1 << PAGE_W;
  localparam logic [BLOCK_W:0]   SCAN_LAST = (BLOCK_W+1)'(BLOCK_NUM);
  localparam logic [BLOCK_W-1:0] BLK_LAST  = BLOCK_W'(BLOCK_NUM - 1);
  localparam logic [PAGE_W-1:0]  PAGE_LAST = PAGE_W'(PAGE_NUM - 1);
  localparam logic [PAGE_W+1:0]  VCNT_NONE = (PAGE_W+2)'(PAGE_NUM + 1);
  localparam logic [PAGE_W+1:0]  VCNT_FULL = (PAGE_W+2)'(PAGE_NUM);
  localparam logic [1:0]         OP_MOVE   = 2'b01;
  localparam logic [1:0]         OP_ERASE  = 2'b10;

  typedef enum logic [3:0] {
    IDLE, SCAN, PV_REQ, PV_EVAL, MOVE_ISSUE, MOVE_WAIT,
    ERASE_ISSUE, ERASE_WAIT, INTERRUPT, FINISH
  } state_t;

  state_t             r_state, w_state_next;
  logic [BLOCK_W-1:0] r_meta_blk, w_meta_blk_next;
  logic [BLOCK_W:0]   r_scan_cnt, w_scan_cnt_next;
  logic [PAGE_W+1:0]  r_best_vcnt, w_best_vcnt_next;
  logic [BLOCK_W-1:0] r_best_blk, w_best_blk_next;
  logic [PAGE_W-1:0]  r_page, w_page_next;
  logic [BLOCK_W-1:0] r_victim, w_victim_next;
  logic               r_resume_erase, w_resume_erase_next;
  logic               r_gc_ok, w_gc_ok_next;

  logic [BLOCK_W-1:0] w_eval_blk;
  logic [PAGE_W+1:0]  w_eval_vcnt;
  logic               w_take;
  logic [PAGE_W+1:0]  w_fin_vcnt;
  logic [BLOCK_W-1:0] w_fin_blk;

  // Metadata returned this cycle belongs to the address issued one cycle earlier.
  assign w_eval_blk  = BLOCK_W'(r_scan_cnt - 1'b1);
  assign w_eval_vcnt = {1'b0, meta_vcnt};
  assign w_take      = (r_state == SCAN) && (r_scan_cnt != '0) && !meta_free &&
                       (w_eval_blk != active_blk) && (w_eval_vcnt < r_best_vcnt);
  assign w_fin_vcnt  = w_take ? w_eval_vcnt : r_best_vcnt;
  assign w_fin_blk   = w_take ? w_eval_blk  : r_best_blk;

  always_comb begin
    w_state_next        = r_state;
    w_scan_cnt_next     = r_scan_cnt;
    w_best_vcnt_next    = r_best_vcnt;
    w_best_blk_next     = r_best_blk;
    w_page_next         = r_page;
    w_victim_next       = r_victim;
    w_resume_erase_next = r_resume_erase;
    w_gc_ok_next        = r_gc_ok;
    pv_blk    = '0;
    pv_page   = '0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_blk   = '0;
    cmd_page  = '0;
    gc_done   = 1'b0;
    gc_nogain = 1'b0;
    unique case (r_state)
      IDLE: begin
        if ((free_blk_cnt < GC_THRESHOLD) || gc_force) begin
          w_state_next     = SCAN;
          w_scan_cnt_next  = '0;
          w_best_vcnt_next = VCNT_NONE;
          w_best_blk_next  = '0;
        end
      end
      SCAN: begin
        w_scan_cnt_next = r_scan_cnt + 1'b1;
        if (w_take) begin
          w_best_vcnt_next = w_eval_vcnt;
          w_best_blk_next  = w_eval_blk;
        end
        if (r_scan_cnt == SCAN_LAST) begin
          // A victim with every page valid frees nothing, same as no victim.
          if (w_fin_vcnt >= VCNT_FULL) begin
            w_state_next = FINISH;
            w_gc_ok_next = 1'b0;
          end else begin
            w_victim_next = w_fin_blk;
            w_page_next   = '0;
            w_state_next  = (w_fin_vcnt == '0) ? ERASE_ISSUE : PV_REQ;
          end
        end
      end
      PV_REQ: begin
        pv_blk       = r_victim;
        pv_page      = r_page;
        w_state_next = PV_EVAL;
      end
      PV_EVAL: begin
        if (host_req) begin
          w_state_next        = INTERRUPT;
          w_resume_erase_next = 1'b0;
        end else if (pv_valid) begin
          w_state_next = MOVE_ISSUE;
        end else if (r_page == PAGE_LAST) begin
          w_state_next = ERASE_ISSUE;
        end else begin
          w_page_next  = r_page + 1'b1;
          w_state_next = PV_REQ;
        end
      end
      MOVE_ISSUE: begin
        cmd_valid = 1'b1;
        cmd_op    = OP_MOVE;
        cmd_blk   = r_victim;
        cmd_page  = r_page;
        if (cmd_ready) w_state_next = MOVE_WAIT;
      end
      MOVE_WAIT: begin
        if (cmd_done) begin
          if (r_page == PAGE_LAST) begin
            w_state_next = ERASE_ISSUE;
          end else begin
            w_page_next  = r_page + 1'b1;
            w_state_next = PV_REQ;
          end
        end
      end
      ERASE_ISSUE: begin
        if (host_req) begin
          w_state_next        = INTERRUPT;
          w_resume_erase_next = 1'b1;
        end else begin
          cmd_valid = 1'b1;
          cmd_op    = OP_ERASE;
          cmd_blk   = r_victim;
          if (cmd_ready) w_state_next = ERASE_WAIT;
        end
      end
      ERASE_WAIT: begin
        if (cmd_done) begin
          w_state_next = FINISH;
          w_gc_ok_next = 1'b1;
        end
      end
      INTERRUPT: begin
        if (!host_req) w_state_next = r_resume_erase ? ERASE_ISSUE : PV_REQ;
      end
      FINISH: begin
        gc_done      = r_gc_ok;
        gc_nogain    = !r_gc_ok;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    // Address walks only while scanning and parks at the last block for the trailing cycle.
    w_meta_blk_next = '0;
    if ((r_state == SCAN) && (w_state_next == SCAN))
      w_meta_blk_next = (r_meta_blk == BLK_LAST) ? r_meta_blk : r_meta_blk + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state        <= IDLE;
      r_meta_blk     <= '0;
      r_scan_cnt     <= '0;
      r_best_vcnt    <= VCNT_NONE;
      r_best_blk     <= '0;
      r_page         <= '0;
      r_victim       <= '0;
      r_resume_erase <= 1'b0;
      r_gc_ok        <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_meta_blk     <= w_meta_blk_next;
      r_scan_cnt     <= w_scan_cnt_next;
      r_best_vcnt    <= w_best_vcnt_next;
      r_best_blk     <= w_best_blk_next;
      r_page         <= w_page_next;
      r_victim       <= w_victim_next;
      r_resume_erase <= w_resume_erase_next;
      r_gc_ok        <= w_gc_ok_next;
    end
  end

  assign meta_blk  = r_meta_blk;
  assign gc_victim = r_victim;
  assign gc_busy   = (r_state != IDLE);
  assign gc_paused = (r_state == INTERRUPT);

endmodule

// File: tb/tb_nvm_gc_engine.sv
// Self-checking bench for nvm_gc_engine: metadata/bitmap memories, a flash responder
// and an argmin reference model predicting the exact command stream of each GC run.
module tb_nvm_gc_engine;
  localparam int BW = 3;
  localparam int PW = 2;
  localparam int NB = 8;
  localparam int NP = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [BW:0]   free_blk_cnt;
  logic          gc_force, host_req;
  logic [BW-1:0] active_blk;
  logic [BW-1:0] meta_blk;
  logic [PW:0]   meta_vcnt;
  logic          meta_free;
  logic [BW-1:0] pv_blk;
  logic [PW-1:0] pv_page;
  logic          pv_valid;
  logic          cmd_valid;
  logic [1:0]    cmd_op;
  logic [BW-1:0] cmd_blk;
  logic [PW-1:0] cmd_page;
  logic          cmd_ready;
  logic          cmd_done = 1'b0;
  logic          gc_busy, gc_paused, gc_done, gc_nogain;
  logic [BW-1:0] gc_victim;

  int n_cmp = 0;
  int n_bad = 0;
  int vcnt_m[NB];
  bit free_m[NB];
  bit pv_m[NB][NP];
  int ready_delay = 0;
  int flash_lat = 2;
  int vcyc = 0;
  int pend = 0;
  int log_q[$];
  int exp_q[$];
  int exp_victim;
  bit exp_nogain;
  int done_pulses, nogain_pulses, valid_cycles, paused_cycles, stall_cycles, first_cmd_cyc;

  always #5 CLK = ~CLK;

  nvm_gc_engine #(.BLOCK_W(BW), .PAGE_W(PW), .GC_THRESHOLD(4'd8)) dut (
    .CLK(CLK), .RST(RST), .free_blk_cnt(free_blk_cnt), .gc_force(gc_force),
    .host_req(host_req), .active_blk(active_blk), .meta_blk(meta_blk),
    .meta_vcnt(meta_vcnt), .meta_free(meta_free), .pv_blk(pv_blk), .pv_page(pv_page),
    .pv_valid(pv_valid), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_blk(cmd_blk),
    .cmd_page(cmd_page), .cmd_ready(cmd_ready), .cmd_done(cmd_done), .gc_busy(gc_busy),
    .gc_paused(gc_paused), .gc_done(gc_done), .gc_nogain(gc_nogain), .gc_victim(gc_victim)
  );

  // Tables with one-cycle read latency, and a flash layer with programmable ready stall and latency.
  always @(posedge CLK) begin
    meta_vcnt <= (PW+1)'(vcnt_m[meta_blk]);
    meta_free <= free_m[meta_blk];
    pv_valid  <= pv_m[pv_blk][pv_page];
    if (RST) begin
      vcyc <= 0; pend <= 0; cmd_done <= 1'b0;
    end else begin
      vcyc <= (cmd_valid && !cmd_ready) ? vcyc + 1 : 0;
      cmd_done <= 1'b0;
      if (cmd_valid && cmd_ready) pend <= flash_lat;
      else if (pend > 0) begin
        pend <= pend - 1;
        if (pend == 1) cmd_done <= 1'b1;
      end
    end
  end
  assign cmd_ready = (vcyc >= ready_delay);

  function automatic int enc(input int op, input int blk, input int page);
    return op * 256 + blk * 16 + page;
  endfunction

  task automatic load_block(input int b, input bit is_free, input logic [3:0] bits);
    free_m[b] = is_free;
    for (int p = 0; p < NP; p++) pv_m[b][p] = is_free ? 1'b0 : bits[p];
    vcnt_m[b] = is_free ? 0 : $countones(bits);
  endtask

  // Reference: lowest-vcnt usable block (first wins), its valid pages in order, then erase.
  task automatic build_expect();
    int best;
    int bb;
    best = NP + 1; bb = -1;
    exp_q.delete();
    for (int b = 0; b < NB; b++)
      if (!free_m[b] && b != int'(active_blk) && vcnt_m[b] < best) begin
        best = vcnt_m[b]; bb = b;
      end
    exp_nogain = (bb < 0) || (best >= NP);
    exp_victim = bb;
    if (!exp_nogain) begin
      if (best > 0)
        for (int p = 0; p < NP; p++) if (pv_m[bb][p]) exp_q.push_back(enc(1, bb, p));
      exp_q.push_back(enc(2, bb, 0));
    end
  endtask

  task automatic check_all_zero(input string name);
    logic [22:0] outs;
    outs = {meta_blk, pv_blk, pv_page, cmd_valid, cmd_op, cmd_blk, cmd_page,
            gc_busy, gc_paused, gc_done, gc_nogain, gc_victim};
    n_cmp++;
    if (outs !== '0) begin
      n_bad++;
      $display("FAIL %s outputs: got %h want 0", name, outs);
    end
  endtask

  task automatic run_gc(input string name, input int trig_free, input bit use_force,
                        input int pre_page, input bit abort_wait, input int exp_paused);
    int cyc, hold;
    bit seen_busy, ended, stalled, preempted, abort_armed, aborted;
    logic [10:0] prev_cmd;
    cyc = 0; hold = 0; seen_busy = 0; ended = 0; stalled = 0; preempted = 0;
    abort_armed = 0; aborted = 0; prev_cmd = '0;
    build_expect();
    log_q.delete();
    done_pulses = 0; nogain_pulses = 0; valid_cycles = 0; paused_cycles = 0;
    stall_cycles = 0; first_cmd_cyc = -1;
    @(negedge CLK);
    free_blk_cnt = (BW+1)'(trig_free); gc_force = use_force;
    for (int t = 0; t < 3000 && !ended; t++) begin
      @(negedge CLK);
      if (abort_armed) begin
        n_cmp++;
        if (!(gc_busy && !cmd_valid)) begin
          n_bad++; $display("FAIL %s in_move_wait: busy=%b valid=%b want 1/0", name, gc_busy, cmd_valid);
        end
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check_all_zero({name, "_after_rst"});
        aborted = 1; ended = 1;
      end else begin
        if (hold > 0) begin
          hold--;
          if (hold == 0) host_req = 1'b0;
        end
        if (gc_busy && !seen_busy) begin
          seen_busy = 1; free_blk_cnt = 4'd10; gc_force = 1'b0;
        end
        if (gc_busy) begin
          if (cyc <= NB) begin
            n_cmp++;
            if (meta_blk !== BW'((cyc < NB) ? cyc : NB - 1)) begin
              n_bad++; $display("FAIL %s scan_addr cyc %0d: got %0d want %0d", name, cyc, meta_blk, (cyc < NB) ? cyc : NB - 1);
            end
          end
          if (pre_page >= 0 && !preempted && cyc > NB && int'(pv_page) == pre_page) begin
            host_req = 1'b1; hold = 11; preempted = 1;
          end
          if (cmd_valid && first_cmd_cyc < 0) first_cmd_cyc = cyc;
          if (cmd_valid) valid_cycles++;
          if (gc_paused) paused_cycles++;
          if (stalled) begin
            n_cmp++;
            if ({cmd_valid, cmd_op, cmd_blk, cmd_page} !== prev_cmd) begin
              n_bad++; $display("FAIL %s stall_hold: got %h want %h", name, {cmd_valid, cmd_op, cmd_blk, cmd_page}, prev_cmd);
            end
          end
          stalled = cmd_valid && !cmd_ready;
          prev_cmd = {cmd_valid, cmd_op, cmd_blk, cmd_page};
          if (stalled) stall_cycles++;
          if (cmd_valid && cmd_ready) begin
            log_q.push_back(enc(int'(cmd_op), int'(cmd_blk), (cmd_op == 2'b01) ? int'(cmd_page) : 0));
            if (abort_wait && cmd_op == 2'b01) abort_armed = 1;
          end
          cyc++;
        end
        if (gc_done) done_pulses++;
        if (gc_nogain) nogain_pulses++;
        if (gc_done || gc_nogain) ended = 1;
      end
    end
    n_cmp++;
    if (!ended) begin
      n_bad++; $display("FAIL %s timeout: got no completion want completion", name);
    end
    if (aborted || !ended) return;
    repeat (2) begin
      @(negedge CLK);
      if (gc_done) done_pulses++;
      if (gc_nogain) nogain_pulses++;
    end
    n_cmp++;
    if (done_pulses != (exp_nogain ? 0 : 1) || nogain_pulses != (exp_nogain ? 1 : 0)) begin
      n_bad++; $display("FAIL %s pulses: got done=%0d nogain=%0d want done=%0d nogain=%0d",
                        name, done_pulses, nogain_pulses, !exp_nogain, exp_nogain);
    end
    n_cmp++;
    if (log_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL %s cmd_count: got %0d want %0d", name, log_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (log_q[i] != exp_q[i]) begin
          n_bad++; $display("FAIL %s cmd[%0d]: got %h want %h", name, i, log_q[i], exp_q[i]);
        end
      end
    end
    if (!exp_nogain) begin
      n_cmp++;
      if (int'(gc_victim) != exp_victim) begin
        n_bad++; $display("FAIL %s victim: got %0d want %0d", name, gc_victim, exp_victim);
      end
    end
    n_cmp++;
    if (paused_cycles != exp_paused || gc_busy !== 1'b0) begin
      n_bad++; $display("FAIL %s paused/idle: got paused=%0d busy=%b want %0d/0", name, paused_cycles, gc_busy, exp_paused);
    end
    $display("run %s: cmds=%0d victim=%0d nogain=%0b paused=%0d", name, log_q.size(), exp_victim, exp_nogain, paused_cycles);
  endtask

  task automatic load_plan_table();
    load_block(0, 0, 4'b1111); load_block(1, 0, 4'b1011);
    load_block(2, 0, 4'b0010); load_block(3, 0, 4'b0001);
    load_block(4, 0, 4'b1111); load_block(5, 1, 4'b0000);
    load_block(6, 0, 4'b0101); load_block(7, 0, 4'b1111);
    active_blk = 3'd7;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    RST = 1'b0;
  endtask

  task automatic test_plan();
    load_plan_table();
    run_gc("plan", 2, 0, -1, 0, 0);
  endtask

  task automatic test_nogain();
    for (int b = 0; b < NB; b++) load_block(b, 0, 4'b1111);
    load_block(3, 0, 4'b0001); load_block(6, 1, 4'b0000);
    active_blk = 3'd3;
    run_gc("nogain", 2, 0, -1, 0, 0);
    n_cmp++;
    if (valid_cycles != 0) begin
      n_bad++; $display("FAIL nogain cmd_valid_cycles: got %0d want 0", valid_cycles);
    end
  endtask

  task automatic test_zero_vcnt();
    for (int b = 0; b < NB; b++) load_block(b, 0, 4'b1111);
    load_block(0, 0, 4'b0000); load_block(1, 1, 4'b0000); load_block(4, 0, 4'b0000);
    active_blk = 3'd0;
    run_gc("zero_vcnt", 10, 1, -1, 0, 0);
    n_cmp++;
    if (first_cmd_cyc != NB + 1) begin
      n_bad++; $display("FAIL zero_vcnt erase_latency: got %0d want %0d", first_cmd_cyc, NB + 1);
    end
  endtask

  task automatic test_threshold();
    load_plan_table();
    @(negedge CLK);
    free_blk_cnt = 4'd8;
    repeat (5) begin
      @(negedge CLK);
      n_cmp++;
      if (gc_busy !== 1'b0) begin
        n_bad++; $display("FAIL threshold_at_8 busy: got %b want 0", gc_busy);
      end
    end
    run_gc("threshold_7", 7, 0, -1, 0, 0);
  endtask

  task automatic test_preempt();
    load_plan_table();
    load_block(2, 0, 4'b0101);
    run_gc("preempt", 2, 0, 2, 0, 10);
  endtask

  task automatic test_ready_stall();
    load_plan_table();
    ready_delay = 5;
    run_gc("ready_stall", 2, 0, -1, 0, 0);
    n_cmp++;
    if (stall_cycles != 10) begin
      n_bad++; $display("FAIL ready_stall stall_cycles: got %0d want 10", stall_cycles);
    end
    ready_delay = 0;
  endtask

  task automatic test_reset_mid();
    load_plan_table();
    flash_lat = 20;
    run_gc("rst_mid", 2, 0, -1, 1, 0);
    flash_lat = 2;
    run_gc("after_rst", 2, 0, -1, 0, 0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      for (int b = 0; b < NB; b++)
        load_block(b, ($urandom_range(0, 5) == 0), 4'($urandom_range(0, 15) | $urandom_range(0, 15)));
      active_blk  = BW'($urandom_range(0, NB - 1));
      ready_delay = $urandom_range(0, 2);
      flash_lat   = $urandom_range(1, 4);
      run_gc($sformatf("random%0d", it), $urandom_range(0, 7), 1'($urandom_range(0, 1)), -1, 0, 0);
    end
    ready_delay = 0;
    flash_lat = 2;
  endtask

  initial begin
    free_blk_cnt = 4'd10; gc_force = 1'b0; host_req = 1'b0; active_blk = '0;
    for (int b = 0; b < NB; b++) load_block(b, 1, 4'b0000);
    test_reset();
    test_plan();
    test_nogain();
    test_zero_vcnt();
    test_threshold();
    test_preempt();
    test_ready_stall();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nvm_gc_engine.md
# nvm_gc_engine

Parametrised garbage-collection engine for the NVM flush controller. When free flash blocks fall below a programmable threshold, or on a software force, it scans block metadata for a greedy victim (fewest valid pages), relocates each valid page through the flash command port, erases the victim and reports completion. Host traffic may preempt it between page operations. It sits between the block/page metadata tables and the flash command layer.

## Interface
- BLOCK_W, 10, block index width; BLOCK_NUM = 2^BLOCK_W
- PAGE_W, 6, page index width; PAGE_NUM = 2^PAGE_W
- GC_THRESHOLD, 8, GC starts when free_blk_cnt < GC_THRESHOLD (width BLOCK_W+1)

- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- free_blk_cnt  in  BLOCK_W+1  current count of free blocks
- gc_force  in  1  start GC regardless of threshold (sampled in IDLE)
- host_req  in  1  host access pending; requests preemption
- active_blk  in  BLOCK_W  block currently open for writes; never a victim
- meta_blk  out  BLOCK_W  metadata read address
- meta_vcnt  in  PAGE_W+1  valid-page count of meta_blk, valid 1 cycle after address
- meta_free  in  1  meta_blk is erased/free, same timing as meta_vcnt
- pv_blk, pv_page  out  BLOCK_W, PAGE_W  page-valid bitmap address
- pv_valid  in  1  page valid bit, valid 1 cycle after address
- cmd_valid  out  1  flash command request
- cmd_op  out  2  01 = MOVE page, 10 = ERASE block
- cmd_blk, cmd_page  out  BLOCK_W, PAGE_W  command target
- cmd_ready  in  1  flash layer accepts command (transfer when cmd_valid & cmd_ready)
- cmd_done  in  1  one-cycle pulse, accepted command finished
- gc_busy  out  1  high in any state but IDLE
- gc_paused  out  1  high in INTERRUPT
- gc_done  out  1  one-cycle pulse: victim erased
- gc_nogain  out  1  one-cycle pulse: no usable victim, GC ended without erase
- gc_victim  out  BLOCK_W  selected victim, held until next scan

## Operation
- States: IDLE, SCAN, PV_REQ, PV_EVAL, MOVE_ISSUE, MOVE_WAIT, ERASE_ISSUE, ERASE_WAIT, INTERRUPT, FINISH.
- IDLE -> SCAN when free_blk_cnt < GC_THRESHOLD or gc_force; meta_blk starts at 0.
- SCAN: meta_blk increments each cycle; data for block i evaluated the next cycle. Candidate iff meta_free=0 and i != active_blk. Replace best when vcnt strictly less than best (ties: lowest index). Best initialised to PAGE_NUM+1 (none).
- End of scan: best vcnt >= PAGE_NUM or no candidate -> FINISH with gc_nogain; vcnt = 0 -> ERASE_ISSUE directly; else PV_REQ with page = 0, gc_victim latched.
- PV_REQ: drive pv_blk/pv_page. PV_EVAL: if host_req -> INTERRUPT (page index held); elif pv_valid -> MOVE_ISSUE; elif page = PAGE_NUM-1 -> ERASE_ISSUE; else page+1, PV_REQ.
- MOVE_ISSUE: cmd_valid=1, op 01, hold stable until cmd_ready; then MOVE_WAIT. MOVE_WAIT on cmd_done: last page -> ERASE_ISSUE, else page+1 -> PV_REQ.
- ERASE_ISSUE: if host_req -> INTERRUPT (resumes at ERASE_ISSUE); else op 10 until accepted -> ERASE_WAIT -> on cmd_done -> FINISH with gc_done.
- INTERRUPT: outputs idle; on host_req=0 return to PV_REQ (same page) or ERASE_ISSUE.
- FINISH: pulses, 1 cycle, -> IDLE. gc_force during a run is ignored.
- host_req never aborts an accepted command; it is ignored in SCAN, MOVE_*, ERASE_WAIT.

## Timing
- Reset: state IDLE; all outputs 0 incl. gc_victim, meta_blk, pv_*, cmd_*. Reset mid-run abandons any outstanding command without waiting for cmd_done.
- Trigger to first meta_blk=0: 1 cycle. SCAN lasts BLOCK_NUM+1 cycles.
- Invalid page: 2 cycles. Valid page: 2 + handshake + flash latency + 1.
- cmd_done outside a WAIT state is ignored.
- Page counter wraps never: last page leads to erase. meta_blk saturates at BLOCK_NUM-1 for the trailing cycle.

## Test plan
- BLOCK_W=3,PAGE_W=2, free=2<8; vcnt {4,3,1,1,4,free,2,4}, active=7 -> victim 2; moves only its valid pages; erase blk 2; gc_done once.
- All non-free blocks vcnt=4 -> gc_nogain pulse, no cmd_valid ever asserted.
- Victim vcnt=0 -> ERASE issued immediately after scan, zero MOVE commands.
- host_req high in PV_EVAL of page 2 for 10 cycles -> gc_paused 10 cycles, resumes at page 2, no duplicate MOVE.
- cmd_ready low 5 cycles -> cmd_valid/op/blk/page stable throughout; single transfer.
- RST mid MOVE_WAIT -> next cycle IDLE, all outputs 0; new trigger restarts scan at block 0.
